// File: rtl/hack_pkg.sv
// Shared Hack ALU types, opcodes and the Not16 inverter.
// Imported by the ALU pipeline and its operand pre-processor.
package hack_pkg;

  localparam int HACK_W = 16;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam logic [5:0] ALU_ZERO      = 6'b101010;
  localparam logic [5:0] ALU_ONE       = 6'b111111;
  localparam logic [5:0] ALU_NEG1      = 6'b111010;
  localparam logic [5:0] ALU_X         = 6'b001100;
  localparam logic [5:0] ALU_X_PLUS_Y  = 6'b000010;
  localparam logic [5:0] ALU_X_MINUS_Y = 6'b010011;
  localparam logic [5:0] ALU_X_AND_Y   = 6'b000000;

  // Not16: bitwise inverter used for operand and result negation
  function automatic logic [HACK_W-1:0] not16(
    input logic [HACK_W-1:0] a
  );
    return ~a;
  endfunction

endpackage

// File: rtl/alu_operand_pre.sv
// Hack ALU operand pre-processing: optional zero, then optional invert.
// Purely combinational; one instance per operand.
module alu_operand_pre
  import hack_pkg::*;
(
  input  logic [HACK_W-1:0] op_i,
  input  logic              zero_i,
  input  logic              inv_i,
  output logic [HACK_W-1:0] op_o
);

  logic [HACK_W-1:0] z;

  assign z    = zero_i ? '0 : op_i;
  assign op_o = inv_i ? not16(z) : z;

endmodule

// File: rtl/alu16_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready flow control.
// S1 holds pre-processed operands, S2 holds result and flags.
module alu16_pipe
  import hack_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  alu_ctrl_t c;
  assign c = alu_ctrl_t'(ctrl);

  logic [HACK_W-1:0] xp, yp;

  alu_operand_pre u_pre_x (
    .op_i   (x),
    .zero_i (c.zx),
    .inv_i  (c.nx),
    .op_o   (xp)
  );

  alu_operand_pre u_pre_y (
    .op_i   (y),
    .zero_i (c.zy),
    .inv_i  (c.ny),
    .op_o   (yp)
  );

  logic              s1_valid_q, s1_valid_d;
  logic [HACK_W-1:0] xp_q, xp_d;
  logic [HACK_W-1:0] yp_q, yp_d;
  logic              f_q, f_d;
  logic              no_q, no_d;

  logic              s2_valid_q, s2_valid_d;
  logic [HACK_W-1:0] out_q, out_d;
  logic              zr_q, zr_d;
  logic              ng_q, ng_d;

  logic              s1_adv, s2_adv;
  logic [HACK_W-1:0] r, res;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // S1 next state: capture operands only on an accepted op
  always_comb begin
    s1_valid_d = s1_valid_q;
    xp_d       = xp_q;
    yp_d       = yp_q;
    f_d        = f_q;
    no_d       = no_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        xp_d = xp;
        yp_d = yp;
        f_d  = c.f;
        no_d = c.no;
      end
    end
  end

  // S1 registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      xp_q       <= '0;
      yp_q       <= '0;
      f_q        <= 1'b0;
      no_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      f_q        <= f_d;
      no_q       <= no_d;
    end
  end

  assign r   = f_q ? (xp_q + yp_q) : (xp_q & yp_q);
  assign res = no_q ? not16(r) : r;

  // S2 next state: take S1 contents when it moves forward
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = res;
        zr_d  = (res == '0);
        ng_d  = res[HACK_W-1];
      end
    end
  end

  // S2 registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;

endmodule

// File: tb/tb_alu16_pipe.sv
// Bench for alu16_pipe: directed cases plus randomized stream
// against an arithmetic reference model and expected-result queue.
module tb_alu16_pipe;
  import hack_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [5:0]  ctrl = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;
  logic        zr;
  logic        ng;

  alu16_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] expq[$];
  logic [17:0] pend;
  bit          acc_last;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {out, zr, ng} from the Hack rules, with plain integer arithmetic
  function automatic logic [17:0] ref_alu(
    input logic [15:0] a, input logic [15:0] b, input logic [5:0] c
  );
    int unsigned xa, yb, rr;
    logic [15:0] o;
    xa = c[5] ? 0 : int'(a);
    if (c[4]) xa = 65535 - xa;
    yb = c[3] ? 0 : int'(b);
    if (c[2]) yb = 65535 - yb;
    rr = c[1] ? (xa + yb) % 65536 : (xa & yb);
    if (c[0]) rr = 65535 - rr;
    o = rr[15:0];
    return {o, (rr == 0), (rr >= 32768)};
  endfunction

  // one clock: score outputs at negedge, then advance past posedge
  task automatic tick();
    logic [17:0] e;
    @(negedge clk);
    acc_last = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_out", 32'(out), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("result", 32'({out, zr, ng}), 32'(e));
      end
    end
    if (acc_last) expq.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [15:0] a, input logic [15:0] b,
    input logic [5:0] c, input logic [17:0] e, input bit rnd
  );
    int n;
    n = 0;
    x = a; y = b; ctrl = c; pend = e; in_valid = 1'b1;
    do begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!acc_last && n < 50);
    if (!acc_last) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (expq.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(expq.size()), 0);
  endtask

  logic [15:0] dx[8];
  logic [15:0] dy[8];
  logic [5:0]  dc[8];
  logic [17:0] de[8];
  logic [18:0] snap;

  initial begin
    dx[0] = 16'd5;    dy[0] = 16'd3;    dc[0] = ALU_X_MINUS_Y;
    de[0] = {16'h0002, 1'b0, 1'b0};
    dx[1] = 16'd3;    dy[1] = 16'd5;    dc[1] = ALU_X_MINUS_Y;
    de[1] = {16'hFFFE, 1'b0, 1'b1};
    dx[2] = 16'h1234; dy[2] = 16'hABCD; dc[2] = ALU_ZERO;
    de[2] = {16'h0000, 1'b1, 1'b0};
    dx[3] = 16'h4321; dy[3] = 16'h0F0F; dc[3] = ALU_NEG1;
    de[3] = {16'hFFFF, 1'b0, 1'b1};
    dx[4] = 16'h7FFF; dy[4] = 16'h0001; dc[4] = ALU_X_PLUS_Y;
    de[4] = {16'h8000, 1'b0, 1'b1};
    dx[5] = 16'h9999; dy[5] = 16'h2222; dc[5] = ALU_ONE;
    de[5] = {16'h0001, 1'b0, 1'b0};
    dx[6] = 16'hF0F0; dy[6] = 16'h3C3C; dc[6] = ALU_X_AND_Y;
    de[6] = {16'h3030, 1'b0, 1'b0};
    dx[7] = 16'hFFFF; dy[7] = 16'h0001; dc[7] = ALU_X_PLUS_Y;
    de[7] = {16'h0000, 1'b1, 1'b0};

    repeat (2) tick();
    reset_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_zr", 32'(zr), 0);
    chk("rst_ng", 32'(ng), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // latency: 5+3 visible after two rising edges
    out_ready = 1'b1;
    x = 16'd5; y = 16'd3; ctrl = ALU_X_PLUS_Y;
    pend = {16'h0008, 1'b0, 1'b0};
    in_valid = 1'b1;
    tick();
    chk("lat_accept", 32'(acc_last), 1);
    in_valid = 1'b0;
    chk("lat1_valid", 32'(out_valid), 0);
    tick();
    chk("lat2_valid", 32'(out_valid), 1);
    chk("lat2_out", 32'(out), 32'h8);
    chk("lat2_flags", 32'({zr, ng}), 0);
    drain();

    for (int i = 0; i < 8; i++) send(dx[i], dy[i], dc[i], de[i], 1'b0);
    drain();

    // stall: two fill the pipe, the third is held off
    out_ready = 1'b0;
    x = 16'd5; y = 16'd3; ctrl = ALU_X_PLUS_Y;
    pend = {16'h0008, 1'b0, 1'b0}; in_valid = 1'b1;
    tick();
    chk("stall_acc_a", 32'(acc_last), 1);
    x = 16'd3; y = 16'd5; ctrl = ALU_X_MINUS_Y;
    pend = {16'hFFFE, 1'b0, 1'b1};
    tick();
    chk("stall_acc_b", 32'(acc_last), 1);
    x = 16'h7FFF; y = 16'd1; ctrl = ALU_X_PLUS_Y;
    pend = {16'h8000, 1'b0, 1'b1};
    chk("stall_full_ready", 32'(in_ready), 0);
    snap = {out_valid, out, zr, ng};
    repeat (3) tick();
    chk("stall_c_blocked", 32'(acc_last), 0);
    chk("stall_hold", 32'({out_valid, out, zr, ng}), 32'(snap));
    chk("stall_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    for (int n = 0; n < 10 && !acc_last; n++) tick();
    chk("stall_c_accept", 32'(acc_last), 1);
    drain();

    // reset with two ops in flight
    out_ready = 1'b0;
    send(16'h0, 16'h0, ALU_NEG1, {16'hFFFF, 1'b0, 1'b1}, 1'b0);
    send(16'h0, 16'h0, ALU_ONE, {16'h0001, 1'b0, 1'b0}, 1'b0);
    chk("rst2_pre_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    expq.delete();
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_out", 32'(out), 0);
    chk("rst2_flags", 32'({zr, ng}), 0);
    chk("rst2_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst2_no_ghost", 32'(out_valid), 0);
    send(16'd5, 16'd3, ALU_X_PLUS_Y, {16'h0008, 1'b0, 1'b0}, 1'b0);
    drain();

    // randomized stream with random backpressure and bubbles
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra, rb;
      logic [5:0]  rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 6'($urandom);
      if (i % 7 == 0) rc = ALU_X_PLUS_Y;
      send(ra, rb, rc, ref_alu(ra, rb, rc), 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
